// File: rtl/mesi_isc_cbus_agent.sv
// rtl/mesi_isc_cbus_agent.sv - MESI snoop responder with line-state table; optional write-back under MESI_ISC_CBUS_WB_EN
module mesi_isc_cbus_agent #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINES      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0] cbus_addr_i,
    output logic                  cbus_ack_o,
    output logic [2:0]            mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0] mbus_addr_o,
    input  logic                  mbus_ack_i,
    input  logic                  loc_wr_i,
    input  logic [ADDR_WIDTH-1:0] loc_addr_i,
    output logic                  loc_busy_o,
    output logic [2*LINES-1:0]    line_state_o
);
    localparam int IDX_W = $clog2(LINES);

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] WR_SNOOP = 3'd1;
    localparam logic [2:0] RD_SNOOP = 3'd2;
    localparam logic [2:0] EN_WR    = 3'd3;
    localparam logic [2:0] EN_RD    = 3'd4;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_WAIT, ACK, DROP} state_t;

    state_t                state, state_nxt;
    logic [2:0]            cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] tag_q [LINES];
    logic [1:0]            st_q  [LINES];

    logic [IDX_W-1:0] cmd_idx, loc_idx;
    logic             cmd_hit, loc_hit, wb_hit;

    assign cmd_idx = addr_q[IDX_W+1:2];
    assign loc_idx = loc_addr_i[IDX_W+1:2];
    assign cmd_hit = (st_q[cmd_idx] != ST_I) && (tag_q[cmd_idx] == addr_q);
    assign loc_hit = (st_q[loc_idx] != ST_I) && (tag_q[loc_idx] == loc_addr_i);

`ifdef MESI_ISC_CBUS_WB_EN
    assign wb_hit = cmd_hit && (st_q[cmd_idx] == ST_M) &&
                    ((cmd_q == WR_SNOOP) || (cmd_q == RD_SNOOP));
`else
    assign wb_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cbus_cmd_i != CMD_NOP) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = wb_hit ? WB_REQ : ACK;
            WB_REQ:  state_nxt = WB_WAIT;
            WB_WAIT: if (mbus_ack_i) state_nxt = ACK;
            ACK:     state_nxt = DROP;
            DROP:    if (cbus_cmd_i == CMD_NOP) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the registered state only, so no input reaches an output combinationally.
    always_comb begin
        cbus_ack_o  = (state == ACK);
        loc_busy_o  = (state != IDLE);
`ifdef MESI_ISC_CBUS_WB_EN
        mbus_cmd_o  = (state == WB_REQ || state == WB_WAIT) ? 3'd1 : 3'd0;
        mbus_addr_o = (state == WB_REQ || state == WB_WAIT) ? addr_q : '0;
`else
        mbus_cmd_o  = 3'd0;
        mbus_addr_o = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_q  <= CMD_NOP;
            addr_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
                st_q[i]  <= ST_I;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cbus_cmd_i != CMD_NOP) begin
                        cmd_q  <= cbus_cmd_i;
                        addr_q <= cbus_addr_i;
                    end else if (loc_wr_i && loc_hit && st_q[loc_idx] >= ST_E) begin
                        st_q[loc_idx] <= ST_M;
                    end
                end
                LOOKUP: begin
                    case (cmd_q)
                        WR_SNOOP: if (cmd_hit && !wb_hit) st_q[cmd_idx] <= ST_I;
                        RD_SNOOP: if (cmd_hit && !wb_hit && st_q[cmd_idx] >= ST_E)
                                      st_q[cmd_idx] <= ST_S;
                        EN_WR: begin
                            tag_q[cmd_idx] <= addr_q;
                            st_q[cmd_idx]  <= ST_M;
                        end
                        EN_RD: begin
                            tag_q[cmd_idx] <= addr_q;
                            st_q[cmd_idx]  <= ST_S;
                        end
                        default: ;
                    endcase
                end
                // Modified data has left the cache only once mbus accepts it.
                WB_WAIT: if (mbus_ack_i)
                    st_q[cmd_idx] <= (cmd_q == WR_SNOOP) ? ST_I : ST_S;
                default: ;
            endcase
        end
    end

    always_comb begin
        line_state_o = '0;
        for (int i = 0; i < LINES; i++) line_state_o[2*i +: 2] = st_q[i];
    end
endmodule

// File: tb/tb_mesi_isc_cbus_agent.sv
// tb/tb_mesi_isc_cbus_agent.sv - scoreboard bench for mesi_isc_cbus_agent against a line-table model
module tb_mesi_isc_cbus_agent;
`ifdef MESI_ISC_CBUS_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  cbus_cmd_i = 3'd0;
    logic [31:0] cbus_addr_i = 32'd0;
    logic        cbus_ack_o;
    logic [2:0]  mbus_cmd_o;
    logic [31:0] mbus_addr_o;
    logic        mbus_ack_i = 1'b0;
    logic        loc_wr_i = 1'b0;
    logic [31:0] loc_addr_i = 32'd0;
    logic        loc_busy_o;
    logic [7:0]  line_state_o;

    mesi_isc_cbus_agent #(.ADDR_WIDTH(32), .LINES(4)) dut (
        .clk(clk), .rst(rst),
        .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_ack_o(cbus_ack_o),
        .mbus_cmd_o(mbus_cmd_o), .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
        .loc_wr_i(loc_wr_i), .loc_addr_i(loc_addr_i), .loc_busy_o(loc_busy_o),
        .line_state_o(line_state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int       cyc;
        logic [7:0] ls;
    } exp_t;
    exp_t        sb[$];
    exp_t        got;
    bit          exp_busy[int];
    logic [31:0] exp_mb[int];

    // Model: MESI state and tag per line
    int          m_st  [4];
    logic [31:0] m_tag [4];

    function automatic logic [7:0] model_ls();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) v[2*i +: 2] = m_st[i][1:0];
        return v;
    endfunction

    always @(negedge clk) begin
        if (cbus_ack_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack cyc=%0d got ack=1 required no ack", cyc);
            end else begin
                got = sb.pop_front();
                if (got.cyc != cyc) begin
                    errors++;
                    $display("FAIL ack_cycle got cyc=%0d required cyc=%0d", cyc, got.cyc);
                end
                checks++;
                if (line_state_o != got.ls) begin
                    errors++;
                    $display("FAIL line_state_at_ack cyc=%0d got %h required %h", cyc, line_state_o, got.ls);
                end
            end
        end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_ack cyc=%0d required ack at cyc=%0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (mon_en) begin
            checks++;
            if (loc_busy_o != exp_busy.exists(cyc)) begin
                errors++;
                $display("FAIL loc_busy cyc=%0d got %0b required %0b", cyc, loc_busy_o, exp_busy.exists(cyc));
            end
            checks++;
            if (exp_mb.exists(cyc)) begin
                if (mbus_cmd_o != 3'd1 || mbus_addr_o != exp_mb[cyc]) begin
                    errors++;
                    $display("FAIL mbus_req cyc=%0d got cmd=%0d addr=%h required cmd=1 addr=%h",
                             cyc, mbus_cmd_o, mbus_addr_o, exp_mb[cyc]);
                end
            end else if (mbus_cmd_o != 3'd0 || mbus_addr_o != 32'd0) begin
                errors++;
                $display("FAIL mbus_idle cyc=%0d got cmd=%0d addr=%h required cmd=0 addr=0",
                         cyc, mbus_cmd_o, mbus_addr_o);
            end
        end
    end

    // hold_in: cycles the command stays non-NOP (0 = random); k_in: mbus_ack cycle (0 = random)
    task automatic run_cmd(input logic [2:0] cmd, input logic [31:0] addr, input int hold_in,
                           input int k_in, input bit loc_en, input logic [31:0] laddr);
        int idx, k, lat, hold, endr, loc_r, c0;
        bit hit, wb;
        exp_t e;
        idx  = int'(addr[3:2]);
        hit  = (m_st[idx] != 0) && (m_tag[idx] == addr);
        wb   = WB_EN && hit && (m_st[idx] == 3) && (cmd == 3'd1 || cmd == 3'd2);
        k    = wb ? ((k_in != 0) ? k_in : 3 + int'($urandom_range(0, 3))) : 0;
        lat  = wb ? k + 1 : 2;
        case (cmd)
            3'd1: if (hit) m_st[idx] = 0;
            3'd2: if (hit && m_st[idx] >= 2) m_st[idx] = 1;
            3'd3: begin m_tag[idx] = addr; m_st[idx] = 3; end
            3'd4: begin m_tag[idx] = addr; m_st[idx] = 1; end
            default: ;
        endcase
        hold  = (hold_in != 0) ? hold_in : 1 + int'($urandom_range(0, lat + 3));
        endr  = ((lat + 1 > hold) ? lat + 1 : hold) + 1;
        loc_r = loc_en ? int'($urandom_range(0, endr - 1)) : -1;
        @(posedge clk); #1;
        c0 = cyc;
        e.cyc = c0 + lat;
        e.ls  = model_ls();
        sb.push_back(e);
        for (int r = 1; r < endr; r++) exp_busy[c0 + r] = 1'b1;
        if (wb) for (int r = 2; r <= k; r++) exp_mb[c0 + r] = addr;
        for (int r = 0; r <= endr; r++) begin
            cbus_cmd_i  = (r < hold) ? cmd : 3'd0;
            cbus_addr_i = addr;
            mbus_ack_i  = wb && (r == k);
            loc_wr_i    = (r == loc_r);
            loc_addr_i  = laddr;
            @(posedge clk); #1;
        end
        cbus_cmd_i = 3'd0;
        mbus_ack_i = 1'b0;
        loc_wr_i   = 1'b0;
    endtask

    task automatic run_loc(input logic [31:0] addr);
        int idx;
        idx = int'(addr[3:2]);
        if (m_st[idx] >= 2 && m_tag[idx] == addr) m_st[idx] = 3;
        @(posedge clk); #1;
        loc_wr_i   = 1'b1;
        loc_addr_i = addr;
        @(posedge clk); #1;
        loc_wr_i   = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (32'($urandom_range(1, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
        return a;
    endfunction

    task automatic check_idle(input string name);
        checks++;
        if (cbus_ack_o !== 1'b0 || mbus_cmd_o !== 3'd0 || mbus_addr_o !== 32'd0 ||
            loc_busy_o !== 1'b0 || line_state_o !== 8'd0) begin
            errors++;
            $display("FAIL %s got ack=%0b mcmd=%0d maddr=%h busy=%0b ls=%h required all zero",
                     name, cbus_ack_o, mbus_cmd_o, mbus_addr_o, loc_busy_o, line_state_o);
        end
    endtask

    initial begin
        int sel, c;
        logic [2:0] cmd;
        for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_tag[i] = 32'd0; end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_idle("reset_state");
        mon_en = 1'b1;

        run_cmd(3'd4, 32'h40, 6, 0, 1'b0, 32'h0);
        run_cmd(3'd3, 32'h44, 0, 0, 1'b0, 32'h0);
        run_cmd(3'd2, 32'h44, 0, 5, 1'b0, 32'h0);
        run_cmd(3'd4, 32'h48, 0, 0, 1'b0, 32'h0);
        run_loc(32'h48);
        run_cmd(3'd3, 32'h48, 0, 0, 1'b0, 32'h0);
        run_cmd(3'd1, 32'h88, 0, 0, 1'b0, 32'h0);
        run_cmd(3'd4, 32'h4C, 0, 0, 1'b0, 32'h0);
        run_cmd(3'd1, 32'h4C, 3, 0, 1'b0, 32'h0);
        @(posedge clk); #1;
        loc_wr_i = 1'b1; loc_addr_i = 32'h4C;
        run_cmd(3'd6, 32'h4C, 0, 0, 1'b0, 32'h0);

        for (int n = 0; n < 70; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 2) begin
                run_loc(rand_addr());
            end else begin
                c = int'($urandom_range(0, 9));
                if (c < 3)      cmd = 3'd1;
                else if (c < 6) cmd = 3'd2;
                else if (c < 8) cmd = 3'd3;
                else if (c < 9) cmd = 3'd4;
                else            cmd = 3'($urandom_range(5, 7));
                run_cmd(cmd, rand_addr(), 0, 0, 1'($urandom_range(0, 1)), rand_addr());
            end
        end

        // Reset landing mid-command (in WB_WAIT when write-back is built in).
        run_cmd(3'd3, 32'h44, 0, 0, 1'b0, 32'h0);
        mon_en = 1'b0;
        @(posedge clk); #1;
        cbus_cmd_i = 3'd2; cbus_addr_i = 32'h44;
        repeat (WB_EN ? 3 : 1) begin @(posedge clk); #1; end
        rst = 1'b0;
        cbus_cmd_i = 3'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_tag[i] = 32'd0; end
        @(negedge clk);
        check_idle("reset_mid_op");
        repeat (6) @(posedge clk);
        #1 mon_en = 1'b1;
        run_cmd(3'd3, 32'h4C, 0, 0, 1'b0, 32'h0);
        run_cmd(3'd2, 32'h4C, 0, 0, 1'b0, 32'h0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (line_state_o != model_ls()) begin
            errors++;
            $display("FAIL final_line_state got %h required %h", line_state_o, model_ls());
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_acks got %0d outstanding required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
